load_store_unit: RTL and testbench

- Multi-cycle load/store port between the single-cycle datapath's ALU/register-file outputs and a handshaked external data memory.
- Accepts one LDUR/STUR request per instruction and drives a req/ack bus.
- Stalls the core (freezes PC and register write) until the access completes.
- Returns load data on a registered output that feeds the mem2reg writeback mux.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Handshaked data-memory bus between the load/store unit and external memory.
// The LSU is the master: it owns the request, direction, address and write
// data; memory answers with ack (plus read data) or err.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store port for the single-cycle core. One LDUR/STUR is
// accepted in IDLE, issued on the registered memory bus, and the core is
// stalled until the access completes (DONE) or faults (ERR, sticky until
// reset). Load data is held in a register feeding the mem2reg writeback mux.
module load_store_unit #(
    parameter int TIMEOUT = 255,  // BUSY cycles before fault, 0 = never
    parameter int CNT_W   = 8     // 2**CNT_W must exceed TIMEOUT
) (
    input  logic                      clk,
    input  logic                      resetl,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [63:0]               addr,
    input  logic [63:0]               wdata,
    output logic [63:0]               rdata,
    output logic                      stall,
    output logic                      fault,
    load_store_unit_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Request captured at issue; it drives the bus unchanged while BUSY.
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } lsu_req_t;

    localparam int             TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q,   state_d;
    lsu_req_t         req_q,     req_d;
    logic             bus_req_q, bus_req_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [63:0]      rdata_q,   rdata_d;
    logic             fault_q,   fault_d;

    logic op_any;
    logic op_bad;

    assign op_any = mem_read | mem_write;
    // Both directions at once, or a non doubleword-aligned address, is
    // rejected without touching the bus.
    assign op_bad = (mem_read & mem_write) | (addr[2:0] != 3'b000);

    // Next-state, datapath captures and stall decode for the access FSM.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        bus_req_d = bus_req_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_any) begin
                    // Stall is combinational here so the PC freezes in the
                    // very cycle the memory instruction appears.
                    stall = 1'b1;
                    if (op_bad) begin
                        state_d = ERR;
                    end else begin
                        req_d.we    = mem_write;
                        req_d.addr  = addr;
                        req_d.wdata = wdata;
                        bus_req_d   = 1'b1;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end

            BUSY: begin
                stall = 1'b1;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (bus.bus_err) begin
                    // Error outranks a simultaneous ack; read data is dropped.
                    bus_req_d = 1'b0;
                    state_d   = ERR;
                end else if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!req_q.we) begin
                        rdata_d = bus.bus_rdata;
                    end
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    bus_req_d = 1'b0;
                    state_d   = ERR;
                end
            end

            DONE: begin
                // Single unstalled cycle: the core commits at this edge and
                // presents its next instruction to IDLE.
                state_d = IDLE;
            end

            ERR: begin
                stall     = 1'b1;
                bus_req_d = 1'b0;
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        if (state_d == ERR) begin
            fault_d = 1'b1;
        end
    end

    // State and datapath registers; resetl clears everything, so a reset
    // mid-BUSY drops the request and any late ack finds the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (resetl) begin
            state_q   <= IDLE;
            req_q     <= '0;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            bus_req_q <= bus_req_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    assign rdata         = rdata_q;
    assign fault         = fault_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = req_q.we;
    assign bus.bus_addr  = req_q.addr;
    assign bus.bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit: each task drives one feature and checks
// it inline; expected load data goes through a scoreboard queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetl;
    logic        mem_read, mem_write;
    logic [63:0] addr, wdata;
    logic [63:0] rdata;
    logic        stall, fault;

    load_store_unit_if bif ();

    load_store_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .bus       (bif.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_rdata;

    int          r_stall, r_req;
    logic        r_done, r_we, r_stable;
    logic [63:0] r_addr, r_wdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetl = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        step();
        step();
        resetl = 1'b0;
        last_rdata = 64'h0;
    endtask

    // Drives one instruction and plays the memory: ack/err is raised in the
    // ack_k-th / err_k-th BUSY cycle (0 = never). Returns at the first
    // unstalled cycle or after max_cyc stalled cycles.
    task automatic run_op(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [63:0] wd, input int ack_k, input int err_k,
                          input logic [63:0] rdat, input int max_cyc);
        r_stall = 0; r_req = 0; r_done = 1'b0; r_we = 1'b0;
        r_addr = '0; r_wdata = '0; r_stable = 1'b1;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        #1;
        if (stall) r_stall++;
        @(posedge clk); #1;
        for (int c = 0; c < max_cyc; c++) begin
            if (!stall) begin
                r_done = 1'b1;
                break;
            end
            r_stall++;
            if (bif.bus_req) begin
                r_req++;
                if (r_req == 1) begin
                    r_we = bif.bus_we; r_addr = bif.bus_addr; r_wdata = bif.bus_wdata;
                end else if (bif.bus_we !== r_we || bif.bus_addr !== r_addr ||
                             bif.bus_wdata !== r_wdata) begin
                    r_stable = 1'b0;
                end
                if (r_req == ack_k) begin
                    bif.bus_ack = 1'b1; bif.bus_rdata = rdat;
                end
                if (r_req == err_k) bif.bus_err = 1'b1;
            end
            @(posedge clk); #1;
            bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = '0;
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (stall !== 1'b0 || fault !== 1'b0 || bif.bus_req !== 1'b0 || bif.bus_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall/fault/req/we got %b%b%b%b expected 0000",
                     stall, fault, bif.bus_req, bif.bus_we);
        end
        n_checks++;
        if (rdata !== 64'h0 || bif.bus_addr !== 64'h0 || bif.bus_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h expected 0", rdata,
                     bif.bus_addr, bif.bus_wdata);
        end
    endtask

    task automatic test_load_delayed();
        logic [63:0] exp;
        sb_q.push_back(64'hDEADBEEF_00000001);
        run_op(1'b1, 1'b0, 64'h28, 64'h0, 3, 0, 64'hDEADBEEF_00000001, 20);
        n_checks++;
        if (r_stall !== 4 || r_done !== 1'b1) begin
            n_fail++;
            $display("FAIL load_stall: got %0d cycles done=%b expected 4 done=1", r_stall, r_done);
        end
        n_checks++;
        if (r_req !== 3 || r_addr !== 64'h28 || r_we !== 1'b0 || r_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL load_bus: req %0d addr %h we %b stable %b expected 3 28 0 1",
                     r_req, r_addr, r_we, r_stable);
        end
        exp = sb_q.pop_front();
        n_checks++;
        if (rdata !== exp) begin
            n_fail++;
            $display("FAIL load_rdata: got %h expected %h", rdata, exp);
        end
        last_rdata = exp;
        step();
    endtask

    task automatic test_store_zero_wait();
        run_op(1'b0, 1'b1, 64'h10, 64'h1234, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 20);
        n_checks++;
        if (r_stall !== 2 || r_done !== 1'b1) begin
            n_fail++;
            $display("FAIL store_stall: got %0d done=%b expected 2 done=1", r_stall, r_done);
        end
        n_checks++;
        if (r_req !== 1 || r_we !== 1'b1 || r_wdata !== 64'h1234 || r_addr !== 64'h10) begin
            n_fail++;
            $display("FAIL store_bus: req %0d we %b wdata %h addr %h expected 1 1 1234 10",
                     r_req, r_we, r_wdata, r_addr);
        end
        n_checks++;
        if (rdata !== last_rdata) begin
            n_fail++;
            $display("FAIL store_rdata: got %h expected %h", rdata, last_rdata);
        end
        step();
    endtask

    task automatic test_illegal();
        logic        rd_t[2] = '{1'b1, 1'b1};
        logic        wr_t[2] = '{1'b0, 1'b1};
        logic [63:0] a_t[2]  = '{64'h13, 64'h8};
        for (int i = 0; i < 2; i++) begin
            run_op(rd_t[i], wr_t[i], a_t[i], 64'h77, 1, 0, 64'h5, 6);
            n_checks++;
            if (r_req !== 0 || r_done !== 1'b0 || r_stall !== 7) begin
                n_fail++;
                $display("FAIL illegal_%0d: req %0d done %b stall %0d expected 0 0 7",
                         i, r_req, r_done, r_stall);
            end
            n_checks++;
            if (fault !== 1'b1 || stall !== 1'b1 || rdata !== last_rdata) begin
                n_fail++;
                $display("FAIL illegal_fault_%0d: fault %b stall %b rdata %h expected 1 1 %h",
                         i, fault, stall, rdata, last_rdata);
            end
            do_reset();
            n_checks++;
            if (fault !== 1'b0 || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_clear_%0d: fault %b stall %b expected 0 0", i, fault, stall);
            end
        end
    endtask

    task automatic test_timeout_and_priority();
        run_op(1'b1, 1'b0, 64'h20, 64'h0, 0, 0, 64'h0, 10);
        n_checks++;
        if (r_req !== 4 || fault !== 1'b1 || r_done !== 1'b0 || bif.bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: req %0d fault %b done %b breq %b expected 4 1 0 0",
                     r_req, fault, r_done, bif.bus_req);
        end
        do_reset();
        sb_q.push_back(64'h5555_AAAA_1234_0001);
        run_op(1'b1, 1'b0, 64'h30, 64'h0, 1, 0, 64'h5555_AAAA_1234_0001, 10);
        n_checks++;
        if (rdata !== sb_q[0]) begin
            n_fail++;
            $display("FAIL prio_setup: got %h expected %h", rdata, sb_q[0]);
        end
        last_rdata = sb_q.pop_front();
        step();
        run_op(1'b1, 1'b0, 64'h38, 64'h0, 2, 2, 64'hBAD0_BAD0_BAD0_BAD0, 6);
        n_checks++;
        if (r_req !== 2 || fault !== 1'b1 || r_done !== 1'b0 || rdata !== last_rdata) begin
            n_fail++;
            $display("FAIL err_priority: req %0d fault %b done %b rdata %h expected 2 1 0 %h",
                     r_req, fault, r_done, rdata, last_rdata);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_op();
        run_op(1'b1, 1'b0, 64'h48, 64'h0, 1, 0, 64'h0123_4567_89AB_CDEF, 10);
        step();
        mem_read = 1'b1; addr = 64'h40;
        step();                       // BUSY cycle 1
        mem_read = 1'b0;
        step();                       // BUSY cycle 2
        n_checks++;
        if (bif.bus_req !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_busy: req %b stall %b expected 1 1", bif.bus_req, stall);
        end
        resetl = 1'b1;
        step();
        resetl = 1'b0;
        bif.bus_ack = 1'b1; bif.bus_rdata = 64'hFFFF_0000_FFFF_0000;
        #1;
        n_checks++;
        if (bif.bus_req !== 1'b0 || stall !== 1'b0 || fault !== 1'b0 || rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL midop_reset: req %b stall %b fault %b rdata %h expected 0 0 0 0",
                     bif.bus_req, stall, fault, rdata);
        end
        step();
        bif.bus_ack = 1'b0; bif.bus_rdata = '0;
        n_checks++;
        if (bif.bus_req !== 1'b0 || stall !== 1'b0 || fault !== 1'b0 || rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL late_ack: req %b stall %b fault %b rdata %h expected 0 0 0 0",
                     bif.bus_req, stall, fault, rdata);
        end
        last_rdata = 64'h0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a_t[2] = '{64'h0, 64'h8};
        logic [63:0] d_t[2] = '{64'hA1A1_0000_0000_0001, 64'hB2B2_0000_0000_0002};
        logic [5:0]  pat;
        logic [63:0] exp;
        pat = '0;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(d_t[i]);
            run_op(1'b1, 1'b0, a_t[i], 64'h0, 1, 0, d_t[i], 10);
            pat = {pat[2:0], (r_stall >= 1), (r_stall >= 2), (r_stall >= 3) || !r_done};
            n_checks++;
            if (r_req !== 1 || r_addr !== a_t[i]) begin
                n_fail++;
                $display("FAIL b2b_bus_%0d: req %0d addr %h expected 1 %h", i, r_req, r_addr, a_t[i]);
            end
            exp = sb_q.pop_front();
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("FAIL b2b_rdata_%0d: got %h expected %h", i, rdata, exp);
            end
            last_rdata = exp;
            step();
        end
        n_checks++;
        if (pat !== 6'b110110) begin
            n_fail++;
            $display("FAIL b2b_stall_pattern: got %b expected 110110", pat);
        end
        // Idle cycles with stray bus responses leave everything untouched.
        bif.bus_ack = 1'b1; bif.bus_err = 1'b1; bif.bus_rdata = 64'h1;
        step();
        step();
        bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = '0;
        n_checks++;
        if (rdata !== last_rdata || stall !== 1'b0 || fault !== 1'b0 || bif.bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stray: rdata %h stall %b fault %b req %b expected %h 0 0 0",
                     rdata, stall, fault, bif.bus_req, last_rdata);
        end
    endtask

    initial begin
        resetl = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0;
        bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = '0;
        last_rdata = '0;
        test_reset();
        test_load_delayed();
        test_store_zero_wait();
        test_illegal();
        test_timeout_and_priority();
        test_reset_mid_op();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
